// File: rtl/nn_pkg.sv
// Shared constants and types for the network readout path.
// Scores are two's complement Q8.8.
// Pure declarations: no logic, no latency, no flow control.
package nn_pkg;
    localparam int SCORE_W = 16;
    localparam int NUM_CLASSES_DEF = 10;
    localparam logic [SCORE_W-1:0] SCORE_MIN = 16'h8000;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        DONE,
        HOLD
    } state_t;
endpackage

// File: rtl/argmax_classifier_if.sv
// Score stream in, classification result out.
// Wires only; no latency.
// Both directions use valid/ready; the transfer happens when both are high.
interface argmax_classifier_if
    import nn_pkg::*;
#(
    parameter int DATA_W = SCORE_W,
    parameter int IDX_W  = 4
);
    logic              score_valid;
    logic              score_ready;
    logic [DATA_W-1:0] score_data;
    logic              result_valid;
    logic              result_ready;
    logic [IDX_W-1:0]  result_class;
    logic [DATA_W-1:0] result_score;
    logic [DATA_W-1:0] result_margin;

    modport master (
        output score_valid, score_data, result_ready,
        input  score_ready, result_valid, result_class, result_score, result_margin
    );

    modport slave (
        input  score_valid, score_data, result_ready,
        output score_ready, result_valid, result_class, result_score, result_margin
    );
endinterface

// File: rtl/top2_tracker.sv
// Running best / second-best score tracker with best index.
// One cycle: a qualified update lands on the next clock edge.
// No flow control; the owner decides when upd_en is allowed.
module top2_tracker
    import nn_pkg::*;
#(
    parameter int DATA_W = SCORE_W,
    parameter int IDX_W  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              init,
    input  logic              upd_en,
    input  logic [DATA_W-1:0] score,
    input  logic [IDX_W-1:0]  idx,
    output logic [DATA_W-1:0] best,
    output logic [DATA_W-1:0] second,
    output logic [IDX_W-1:0]  best_idx
);
    localparam logic [DATA_W-1:0] MIN_VAL = {SCORE_MIN[SCORE_W-1], {(DATA_W-1){1'b0}}};

    logic [DATA_W-1:0] best_nxt;
    logic [DATA_W-1:0] second_nxt;
    logic [IDX_W-1:0]  idx_nxt;

    // Strict compare keeps the earlier index on a tie; the tied score still lands in second.
    always_comb begin
        best_nxt   = best;
        second_nxt = second;
        idx_nxt    = best_idx;
        if (init) begin
            best_nxt   = MIN_VAL;
            second_nxt = MIN_VAL;
            idx_nxt    = '0;
        end else if (upd_en) begin
            if ($signed(score) > $signed(best)) begin
                second_nxt = best;
                best_nxt   = score;
                idx_nxt    = idx;
            end else if ($signed(score) > $signed(second)) begin
                second_nxt = score;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            best     <= '0;
            second   <= '0;
            best_idx <= '0;
        end else begin
            best     <= best_nxt;
            second   <= second_nxt;
            best_idx <= idx_nxt;
        end
    end
endmodule

// File: rtl/argmax_classifier.sv
// Reduces each frame of NUM_CLASSES scores to class, score and saturated margin.
// Result valid 2 cycles after the last score transfer (DONE, then HOLD).
// score_ready is low outside ACCUM, so the stream stalls while a result is pending.
module argmax_classifier
    import nn_pkg::*;
#(
    parameter int NUM_CLASSES = NUM_CLASSES_DEF,
    parameter int DATA_W      = SCORE_W,
    parameter int IDX_W       = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    argmax_classifier_if.slave bus,
    output logic              busy,
    output logic              frame_err
);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CLASSES - 1);

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  cnt_q, cnt_d;
    logic              trk_init, trk_upd, load_res, set_err;
    logic              rv_q, rv_d;
    logic [DATA_W-1:0] best, second;
    logic [IDX_W-1:0]  best_idx;
    logic signed [DATA_W:0] diff;
    logic [DATA_W-1:0] margin;
    logic [IDX_W-1:0]  class_q;
    logic [DATA_W-1:0] score_q, margin_q;

    top2_tracker #(.DATA_W(DATA_W), .IDX_W(IDX_W)) u_tracker (
        .clk      (clk),
        .reset    (reset),
        .init     (trk_init),
        .upd_en   (trk_upd),
        .score    (bus.score_data),
        .idx      (cnt_q),
        .best     (best),
        .second   (second),
        .best_idx (best_idx)
    );

    // best >= second always, so the top bit only rises on overflow of the unsigned field.
    assign diff   = $signed({best[DATA_W-1], best}) - $signed({second[DATA_W-1], second});
    assign margin = diff[DATA_W] ? '1 : diff[DATA_W-1:0];

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rv_d     = rv_q;
        trk_init = 1'b0;
        trk_upd  = 1'b0;
        load_res = 1'b0;
        set_err  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = ACCUM;
                    cnt_d    = '0;
                    trk_init = 1'b1;
                end
            end
            ACCUM: begin
                // A restart wins over any score presented in the same cycle.
                if (start) begin
                    cnt_d    = '0;
                    trk_init = 1'b1;
                    set_err  = (cnt_q != '0);
                end else if (bus.score_valid) begin
                    trk_upd = 1'b1;
                    if (cnt_q == LAST_IDX) begin
                        state_d = DONE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            DONE: begin
                load_res = 1'b1;
                rv_d     = 1'b1;
                state_d  = HOLD;
            end
            HOLD: begin
                if (rv_q && bus.result_ready) begin
                    rv_d = 1'b0;
                    if (start) begin
                        state_d  = ACCUM;
                        cnt_d    = '0;
                        trk_init = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            rv_q      <= 1'b0;
            class_q   <= '0;
            score_q   <= '0;
            margin_q  <= '0;
            frame_err <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rv_q    <= rv_d;
            if (load_res) begin
                class_q  <= best_idx;
                score_q  <= best;
                margin_q <= margin;
            end
            if (set_err) begin
                frame_err <= 1'b1;
            end
        end
    end

    assign bus.score_ready   = (state_q == ACCUM);
    assign busy              = (state_q == ACCUM);
    assign bus.result_valid  = rv_q;
    assign bus.result_class  = class_q;
    assign bus.result_score  = score_q;
    assign bus.result_margin = margin_q;
endmodule

// File: tb/tb_argmax_classifier.sv
// Scenario-driven bench for argmax_classifier with an expected-result queue.
module tb_argmax_classifier;
    import nn_pkg::*;

    localparam int NC = 10;
    localparam int DW = 16;
    localparam int IW = 4;

    typedef logic [DW-1:0] frame_t [NC];
    typedef struct {
        logic [IW-1:0] cls;
        logic [DW-1:0] score;
        logic [DW-1:0] margin;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic start = 1'b0;
    logic busy, frame_err;
    int   n_tests = 0;
    int   n_fail = 0;
    exp_t sb[$];

    argmax_classifier_if #(.DATA_W(DW), .IDX_W(IW)) bus();

    argmax_classifier #(.NUM_CLASSES(NC), .DATA_W(DW), .IDX_W(IW)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .bus       (bus),
        .busy      (busy),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
        $fatal(1, "watchdog");
    end

    function automatic int sval(input logic [DW-1:0] x);
        return int'($signed(x));
    endfunction

    // Reference: first maximum wins; second is the largest of all other entries.
    function automatic exp_t model(input frame_t f);
        exp_t e;
        int bi, sec, m;
        bi = 0;
        for (int i = 1; i < NC; i++)
            if (sval(f[i]) > sval(f[bi])) bi = i;
        sec = -100000;
        for (int i = 0; i < NC; i++)
            if (i != bi && sval(f[i]) > sec) sec = sval(f[i]);
        m = sval(f[bi]) - sec;
        if (m > 65535) m = 65535;
        e.cls    = IW'(bi);
        e.score  = f[bi];
        e.margin = DW'(m);
        return e;
    endfunction

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic feed(input frame_t f, output int stalls);
        int guard;
        stalls = 0;
        for (int i = 0; i < NC; i++) begin
            bus.score_valid = 1'b1;
            bus.score_data  = f[i];
            guard = 0;
            while (bus.score_ready !== 1'b1 && guard < 50) begin
                @(negedge clk);
                stalls++;
                guard++;
            end
            @(negedge clk);
        end
        bus.score_valid = 1'b0;
    endtask

    task automatic wait_result(output int cyc);
        cyc = 0;
        while (bus.result_valid !== 1'b1 && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic test_reset();
        bus.score_valid  = 1'b1;
        bus.score_data   = 16'h7FFF;
        bus.result_ready = 1'b1;
        @(negedge clk);
        n_tests++;
        if ({bus.result_valid, bus.score_ready, busy, frame_err} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_ctrl: got rv/srdy/busy/err=%b required 0000",
                     {bus.result_valid, bus.score_ready, busy, frame_err});
        end
        n_tests++;
        if ({bus.result_class, bus.result_score, bus.result_margin} !== 36'd0) begin
            n_fail++;
            $display("FAIL reset_data: got cls=%h score=%h margin=%h required 0",
                     bus.result_class, bus.result_score, bus.result_margin);
        end
        reset = 1'b1;
        repeat (3) @(negedge clk);
        n_tests++;
        if ({bus.score_ready, busy, bus.result_valid} !== 3'b000) begin
            n_fail++;
            $display("FAIL idle_ignores_valid: got srdy/busy/rv=%b required 000",
                     {bus.score_ready, busy, bus.result_valid});
        end
        bus.score_valid = 1'b0;
    endtask

    task automatic test_basic();
        frame_t f;
        exp_t e;
        int st, cyc;
        f = '{16'h0010, 16'h0300, 16'h0100, 16'hFF00, 16'h0050,
              16'h0000, 16'h0200, 16'h0001, 16'h0002, 16'h0003};
        bus.result_ready = 1'b1;
        pulse_start();
        n_tests++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_busy: got %b required 1", busy);
        end
        sb.push_back(model(f));
        feed(f, st);
        n_tests++;
        if (bus.result_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_done_cycle: result_valid=%b required 0", bus.result_valid);
        end
        wait_result(cyc);
        n_tests++;
        if (cyc !== 1) begin
            n_fail++;
            $display("FAIL basic_latency: cycles after DONE=%0d required 1", cyc);
        end
        e = sb.pop_front();
        n_tests++;
        if ({bus.result_class, bus.result_score, bus.result_margin} !== {e.cls, e.score, e.margin}) begin
            n_fail++;
            $display("FAIL basic_model: got %h/%h/%h required %h/%h/%h", bus.result_class,
                     bus.result_score, bus.result_margin, e.cls, e.score, e.margin);
        end
        n_tests++;
        if ({bus.result_class, bus.result_score, bus.result_margin} !== {4'd1, 16'h0300, 16'h0100}) begin
            n_fail++;
            $display("FAIL basic_const: got %h/%h/%h required 1/0300/0100",
                     bus.result_class, bus.result_score, bus.result_margin);
        end
        @(negedge clk);
        n_tests++;
        if ({bus.result_valid, busy} !== 2'b00) begin
            n_fail++;
            $display("FAIL basic_accept: rv/busy=%b required 00", {bus.result_valid, busy});
        end
    endtask

    task automatic test_ties();
        frame_t f;
        exp_t e;
        int st, cyc;
        foreach (f[i]) f[i] = 16'h0000;
        f[2] = 16'h0100;
        f[7] = 16'h0100;
        bus.result_ready = 1'b1;
        pulse_start();
        sb.push_back(model(f));
        feed(f, st);
        wait_result(cyc);
        e = sb.pop_front();
        n_tests++;
        if ({bus.result_class, bus.result_score, bus.result_margin} !== {e.cls, e.score, e.margin}) begin
            n_fail++;
            $display("FAIL ties_model: got %h/%h/%h required %h/%h/%h", bus.result_class,
                     bus.result_score, bus.result_margin, e.cls, e.score, e.margin);
        end
        n_tests++;
        if ({bus.result_class, bus.result_margin} !== {4'd2, 16'h0000}) begin
            n_fail++;
            $display("FAIL ties_const: got cls=%h margin=%h required 2/0000",
                     bus.result_class, bus.result_margin);
        end
        @(negedge clk);
    endtask

    task automatic test_extreme();
        frame_t f;
        exp_t e;
        int st, cyc;
        foreach (f[i]) f[i] = 16'h8000;
        f[4] = 16'h7FFF;
        bus.result_ready = 1'b1;
        pulse_start();
        sb.push_back(model(f));
        feed(f, st);
        wait_result(cyc);
        e = sb.pop_front();
        n_tests++;
        if ({bus.result_class, bus.result_score, bus.result_margin} !== {e.cls, e.score, e.margin}) begin
            n_fail++;
            $display("FAIL spread_model: got %h/%h/%h required %h/%h/%h", bus.result_class,
                     bus.result_score, bus.result_margin, e.cls, e.score, e.margin);
        end
        n_tests++;
        if ({bus.result_class, bus.result_margin} !== {4'd4, 16'hFFFF}) begin
            n_fail++;
            $display("FAIL spread_const: got cls=%h margin=%h required 4/FFFF",
                     bus.result_class, bus.result_margin);
        end
        @(negedge clk);
        foreach (f[i]) f[i] = 16'h8000;
        pulse_start();
        sb.push_back(model(f));
        feed(f, st);
        wait_result(cyc);
        e = sb.pop_front();
        n_tests++;
        if ({bus.result_class, bus.result_score, bus.result_margin} !== {4'd0, 16'h8000, 16'h0000}) begin
            n_fail++;
            $display("FAIL allmin_const: got %h/%h/%h required 0/8000/0000 (model %h/%h/%h)",
                     bus.result_class, bus.result_score, bus.result_margin, e.cls, e.score, e.margin);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        frame_t f1, f2;
        exp_t e;
        int st, cyc, bad;
        foreach (f1[i]) f1[i] = 16'(i * 37 + 5);
        f1[6] = 16'h1234;
        foreach (f2[i]) f2[i] = 16'(16'hF000 + i * 3);
        f2[9] = 16'h0042;
        bus.result_ready = 1'b0;
        pulse_start();
        sb.push_back(model(f1));
        feed(f1, st);
        wait_result(cyc);
        e = sb.pop_front();
        n_tests++;
        if (cyc >= 50) begin
            n_fail++;
            $display("FAIL bp_timeout: no result after %0d cycles", cyc);
        end
        bad = 0;
        for (int k = 0; k < 20; k++) begin
            bus.score_valid = 1'b1;
            bus.score_data  = 16'($urandom);
            @(negedge clk);
            n_tests++;
            if ({bus.score_ready, bus.result_valid, bus.result_class, bus.result_score, bus.result_margin}
                !== {1'b0, 1'b1, e.cls, e.score, e.margin}) begin
                n_fail++;
                bad++;
                if (bad < 3)
                    $display("FAIL bp_hold[%0d]: srdy=%b rv=%b %h/%h/%h required 0/1 %h/%h/%h", k,
                             bus.score_ready, bus.result_valid, bus.result_class, bus.result_score,
                             bus.result_margin, e.cls, e.score, e.margin);
            end
        end
        bus.score_valid  = 1'b0;
        bus.result_ready = 1'b1;
        pulse_start();
        n_tests++;
        if ({busy, bus.score_ready, bus.result_valid} !== 3'b110) begin
            n_fail++;
            $display("FAIL b2b_restart: busy/srdy/rv=%b required 110",
                     {busy, bus.score_ready, bus.result_valid});
        end
        sb.push_back(model(f2));
        feed(f2, st);
        n_tests++;
        if (st !== 0) begin
            n_fail++;
            $display("FAIL b2b_stalls: got %0d stall cycles required 0", st);
        end
        wait_result(cyc);
        e = sb.pop_front();
        n_tests++;
        if ({bus.result_class, bus.result_score, bus.result_margin} !== {e.cls, e.score, e.margin}) begin
            n_fail++;
            $display("FAIL b2b_model: got %h/%h/%h required %h/%h/%h", bus.result_class,
                     bus.result_score, bus.result_margin, e.cls, e.score, e.margin);
        end
        @(negedge clk);
    endtask

    task automatic test_abort();
        frame_t f;
        exp_t e;
        int st, cyc, extra;
        foreach (f[i]) f[i] = 16'(16'h0100 + ((i * 53) % 11) * 16);
        bus.result_ready = 1'b1;
        start = 1'b1;
        @(negedge clk);
        @(negedge clk);
        start = 1'b0;
        n_tests++;
        if ({frame_err, busy} !== 2'b01) begin
            n_fail++;
            $display("FAIL silent_restart: err/busy=%b required 01", {frame_err, busy});
        end
        for (int i = 0; i < 4; i++) begin
            bus.score_valid = 1'b1;
            bus.score_data  = 16'h7F00;
            @(negedge clk);
        end
        start = 1'b1;
        bus.score_data = 16'h7000;
        @(negedge clk);
        start = 1'b0;
        bus.score_valid = 1'b0;
        n_tests++;
        if (frame_err !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_err: frame_err=%b required 1", frame_err);
        end
        sb.push_back(model(f));
        feed(f, st);
        wait_result(cyc);
        e = sb.pop_front();
        n_tests++;
        if ({bus.result_class, bus.result_score, bus.result_margin} !== {e.cls, e.score, e.margin}) begin
            n_fail++;
            $display("FAIL abort_model: got %h/%h/%h required %h/%h/%h", bus.result_class,
                     bus.result_score, bus.result_margin, e.cls, e.score, e.margin);
        end
        extra = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (bus.result_valid === 1'b1) extra++;
        end
        n_tests++;
        if (extra !== 0) begin
            n_fail++;
            $display("FAIL abort_single: extra result_valid cycles=%0d required 0", extra);
        end
    endtask

    task automatic test_async_reset();
        frame_t f;
        exp_t e;
        int st, cyc;
        foreach (f[i]) f[i] = 16'(16'hFE00 + i * 29);
        f[3] = 16'h0077;
        bus.result_ready = 1'b1;
        pulse_start();
        for (int i = 0; i < 5; i++) begin
            bus.score_valid = 1'b1;
            bus.score_data  = 16'h7FFF;
            @(negedge clk);
        end
        #2 reset = 1'b0;
        #1;
        n_tests++;
        if ({busy, bus.score_ready, frame_err, bus.result_valid} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_midframe: busy/srdy/err/rv=%b required 0000",
                     {busy, bus.score_ready, frame_err, bus.result_valid});
        end
        bus.score_valid = 1'b0;
        @(negedge clk);
        #2 reset = 1'b1;
        @(negedge clk);
        bus.result_ready = 1'b0;
        pulse_start();
        feed(f, st);
        wait_result(cyc);
        n_tests++;
        if (bus.result_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL hold_reached: result_valid=%b required 1", bus.result_valid);
        end
        #2 reset = 1'b0;
        #1;
        n_tests++;
        if ({bus.result_valid, busy, bus.result_class, bus.result_score, bus.result_margin} !== 38'd0) begin
            n_fail++;
            $display("FAIL reset_midhold: rv=%b cls=%h score=%h margin=%h required all 0",
                     bus.result_valid, bus.result_class, bus.result_score, bus.result_margin);
        end
        @(negedge clk);
        #2 reset = 1'b1;
        @(negedge clk);
        bus.result_ready = 1'b1;
        pulse_start();
        sb.push_back(model(f));
        feed(f, st);
        wait_result(cyc);
        e = sb.pop_front();
        n_tests++;
        if ({bus.result_class, bus.result_score, bus.result_margin} !== {e.cls, e.score, e.margin}) begin
            n_fail++;
            $display("FAIL post_reset_model: got %h/%h/%h required %h/%h/%h", bus.result_class,
                     bus.result_score, bus.result_margin, e.cls, e.score, e.margin);
        end
        @(negedge clk);
    endtask

    initial begin
        bus.score_valid  = 1'b0;
        bus.score_data   = '0;
        bus.result_ready = 1'b0;
        test_reset();
        test_basic();
        test_ties();
        test_extreme();
        test_back_to_back();
        test_abort();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
